// File: rtl/arst_issue_seq.sv
// Reset issuer/sequencer: drives async resets into remote clock domains and waits on their acks.
// Define ARST_ISSUE_TIMEOUT_EN to bound the ack waits with timeout_cycles_p and report err_o.
module arst_issue_seq #(
  parameter int unsigned num_domains_p    = 2,
  parameter int unsigned hold_cycles_p    = 16,
  parameter int unsigned timeout_cycles_p = 1024
) (
  input  logic                     clk_i,
  input  logic                     async_reset_i,
  input  logic                     req_v_i,
  output logic                     req_ready_o,
  output logic [num_domains_p-1:0] domain_reset_o,
  input  logic [num_domains_p-1:0] domain_ack_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o
);

  if (num_domains_p < 1 || hold_cycles_p < 1 || timeout_cycles_p < 1) begin : g_param_check
    $error("arst_issue_seq: num_domains_p, hold_cycles_p and timeout_cycles_p must be >= 1");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ASSERT,
    ST_HOLD,
    ST_RELEASE,
    ST_DONE
  } state_e;

  localparam int unsigned HW = $clog2(hold_cycles_p + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(hold_cycles_p - 1);

  state_e                   state, state_n;
  logic [HW-1:0]            hold_cnt, hold_cnt_n;
  logic [num_domains_p-1:0] ack_meta, ack_s;
  logic [num_domains_p-1:0] rst_q;

  // Synchronizers power up "in reset" so the post-reset release waits for real acks to fall.
  always_ff @(posedge clk_i or posedge async_reset_i) begin
    if (async_reset_i) begin
      ack_meta <= '1;
      ack_s    <= '1;
    end else begin
      ack_meta <= domain_ack_i;
      ack_s    <= ack_meta;
    end
  end

`ifdef ARST_ISSUE_TIMEOUT_EN
  localparam int unsigned TW = $clog2(timeout_cycles_p + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(timeout_cycles_p - 1);

  logic [TW-1:0] to_cnt, to_cnt_n;
  logic          err_q, err_n;
  logic          to_hit;

  assign to_hit = (to_cnt == TO_LAST);
`endif

  always_comb begin
    state_n    = state;
    hold_cnt_n = hold_cnt;
    unique case (state)
      ST_IDLE:    if (req_v_i) state_n = ST_ASSERT;
      ST_ASSERT: begin
        if (&ack_s) begin
          state_n    = ST_HOLD;
          hold_cnt_n = '0;
        end
      end
      ST_HOLD: begin
        if (hold_cnt != '1) hold_cnt_n = hold_cnt + 1'b1;
        if (hold_cnt == HOLD_LAST) state_n = ST_RELEASE;
      end
      ST_RELEASE: if (~|ack_s) state_n = ST_DONE;
      ST_DONE:    state_n = ST_IDLE;
      default:    state_n = ST_HOLD;
    endcase

`ifdef ARST_ISSUE_TIMEOUT_EN
    // Timeout only overrides a wait whose ack condition is unmet, so a same-cycle ack wins.
    to_cnt_n = to_cnt;
    err_n    = err_q;
    if ((state == ST_ASSERT || state == ST_RELEASE) && to_cnt != '1)
      to_cnt_n = to_cnt + 1'b1;
    unique case (state)
      ST_ASSERT: begin
        if (!(&ack_s) && to_hit) begin
          state_n = ST_RELEASE;
          err_n   = 1'b1;
        end
      end
      ST_RELEASE: begin
        if ((|ack_s) && (err_q || to_hit)) begin
          state_n = ST_DONE;
          err_n   = 1'b1;
        end
      end
      ST_DONE: err_n = 1'b0;
      default: ;
    endcase
    if (state_n != state && (state_n == ST_ASSERT || state_n == ST_RELEASE))
      to_cnt_n = '0;
`endif
  end

  always_ff @(posedge clk_i or posedge async_reset_i) begin
    if (async_reset_i) begin
      state    <= ST_HOLD;
      hold_cnt <= '0;
      rst_q    <= '1;
    end else begin
      state    <= state_n;
      hold_cnt <= hold_cnt_n;
      rst_q    <= {num_domains_p{(state_n == ST_ASSERT) || (state_n == ST_HOLD)}};
    end
  end

`ifdef ARST_ISSUE_TIMEOUT_EN
  always_ff @(posedge clk_i or posedge async_reset_i) begin
    if (async_reset_i) begin
      to_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      to_cnt <= to_cnt_n;
      err_q  <= err_n;
    end
  end

  assign err_o = (state == ST_DONE) && err_q;
`else
  assign err_o = 1'b0;
`endif

  assign domain_reset_o = rst_q;
  assign busy_o         = (state != ST_IDLE);
  assign req_ready_o    = (state == ST_IDLE);
  assign done_o         = (state == ST_DONE);

endmodule

// File: tb/tb_arst_issue_seq.sv
// Directed bench for arst_issue_seq: per-cycle vector table plus power-on and mid-sequence reset runs.
module tb_arst_issue_seq;

  logic       clk_i = 1'b0;
  logic       async_reset_i;
  logic       req_v_i;
  logic       req_ready_o;
  logic [1:0] domain_reset_o;
  logic [1:0] domain_ack_i;
  logic       busy_o;
  logic       done_o;
  logic       err_o;

  int checks   = 0;
  int failures = 0;

  arst_issue_seq #(
    .num_domains_p   (2),
    .hold_cycles_p   (16),
    .timeout_cycles_p(8)
  ) dut (
    .clk_i         (clk_i),
    .async_reset_i (async_reset_i),
    .req_v_i       (req_v_i),
    .req_ready_o   (req_ready_o),
    .domain_reset_o(domain_reset_o),
    .domain_ack_i  (domain_ack_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .err_o         (err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic       req;
    logic [1:0] ack;
    int         n;
    logic [1:0] rst;
    logic       busy;
    logic       ready;
    logic       done;
    logic       err;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic req, input logic [1:0] ack, input int n,
                              input logic [1:0] rst, input logic busy, input logic ready,
                              input logic done, input logic err);
    vec_t v;
    v.req = req; v.ack = ack; v.n = n; v.rst = rst;
    v.busy = busy; v.ready = ready; v.done = done; v.err = err;
    vecs.push_back(v);
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // {domain_reset_o, busy_o, req_ready_o, done_o, err_o}
  function automatic int outs();
    return int'({domain_reset_o, busy_o, req_ready_o, done_o, err_o});
  endfunction

  // Expects async_reset_i just deasserted with acks high; acks drop a few cycles in.
  task automatic reset_run(input string nm);
    int cyc;
    cyc = 0;
    while (domain_reset_o == 2'b11 && cyc < 100) begin
      cyc++;
      if (cyc == 4) domain_ack_i = 2'b00;
      tick();
    end
    check({nm, "_hold_len"}, cyc, 16);
    cyc = 0;
    while (!done_o && cyc < 50) begin
      cyc++;
      tick();
    end
    check({nm, "_release_to_done"}, cyc, 1);
    check({nm, "_done_err"}, int'(err_o), 0);
    tick();
    check({nm, "_idle"}, outs(), int'({2'b00, 1'b0, 1'b1, 1'b0, 1'b0}));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    async_reset_i = 1'b0;
    req_v_i       = 1'b0;
    domain_ack_i  = 2'b11;
    #1 async_reset_i = 1'b1;
    repeat (5) @(posedge clk_i);
    #1;
    check("por_in_reset", outs(), int'({2'b11, 1'b1, 1'b0, 1'b0, 1'b0}));
    async_reset_i = 1'b0;
    reset_run("por");

    // Software request, each domain acking 3 cycles after its reset edge.
    add(1, 2'b00,  1, 2'b11, 1, 0, 0, 0);
    add(0, 2'b00,  2, 2'b11, 1, 0, 0, 0);
    add(0, 2'b11, 18, 2'b11, 1, 0, 0, 0);
    add(0, 2'b11,  1, 2'b00, 1, 0, 0, 0);
    add(0, 2'b11,  2, 2'b00, 1, 0, 0, 0);
    add(0, 2'b00,  2, 2'b00, 1, 0, 0, 0);
    add(0, 2'b00,  1, 2'b00, 1, 0, 1, 0);
    add(0, 2'b00,  1, 2'b00, 0, 1, 0, 0);
`ifndef ARST_ISSUE_TIMEOUT_EN
    // Staggered acks: domain 0 at +2, domain 1 at +20 on both edges.
    add(1, 2'b00,  1, 2'b11, 1, 0, 0, 0);
    add(0, 2'b00,  1, 2'b11, 1, 0, 0, 0);
    add(0, 2'b01, 18, 2'b11, 1, 0, 0, 0);
    add(0, 2'b11, 18, 2'b11, 1, 0, 0, 0);
    add(0, 2'b11,  1, 2'b00, 1, 0, 0, 0);
    add(0, 2'b11,  1, 2'b00, 1, 0, 0, 0);
    add(0, 2'b10, 18, 2'b00, 1, 0, 0, 0);
    add(0, 2'b00,  2, 2'b00, 1, 0, 0, 0);
    add(0, 2'b00,  1, 2'b00, 1, 0, 1, 0);
    add(0, 2'b00,  1, 2'b00, 0, 1, 0, 0);
`endif
    // Request held through a whole sequence: exactly one extra sequence follows.
    add(1, 2'b00,  1, 2'b11, 1, 0, 0, 0);
    add(1, 2'b00,  2, 2'b11, 1, 0, 0, 0);
    add(1, 2'b11, 18, 2'b11, 1, 0, 0, 0);
    add(1, 2'b11,  1, 2'b00, 1, 0, 0, 0);
    add(1, 2'b11,  2, 2'b00, 1, 0, 0, 0);
    add(1, 2'b00,  2, 2'b00, 1, 0, 0, 0);
    add(1, 2'b00,  1, 2'b00, 1, 0, 1, 0);
    add(1, 2'b00,  1, 2'b00, 0, 1, 0, 0);
    add(1, 2'b00,  1, 2'b11, 1, 0, 0, 0);
    add(0, 2'b00,  2, 2'b11, 1, 0, 0, 0);
    add(0, 2'b11, 18, 2'b11, 1, 0, 0, 0);
    add(0, 2'b11,  1, 2'b00, 1, 0, 0, 0);
    add(0, 2'b11,  2, 2'b00, 1, 0, 0, 0);
    add(0, 2'b00,  2, 2'b00, 1, 0, 0, 0);
    add(0, 2'b00,  1, 2'b00, 1, 0, 1, 0);
    add(0, 2'b00,  3, 2'b00, 0, 1, 0, 0);
`ifdef ARST_ISSUE_TIMEOUT_EN
    // Domain 1 stuck low: 8 ASSERT cycles, one RELEASE cycle, DONE with err.
    add(1, 2'b01,  1, 2'b11, 1, 0, 0, 0);
    add(0, 2'b01,  7, 2'b11, 1, 0, 0, 0);
    add(0, 2'b01,  1, 2'b00, 1, 0, 0, 0);
    add(0, 2'b01,  1, 2'b00, 1, 0, 1, 1);
    add(0, 2'b00,  1, 2'b00, 0, 1, 0, 0);
    add(0, 2'b00,  3, 2'b00, 0, 1, 0, 0);
`endif

    foreach (vecs[r]) begin
      for (int c = 0; c < vecs[r].n; c++) begin
        req_v_i      = vecs[r].req;
        domain_ack_i = vecs[r].ack;
        tick();
        check($sformatf("vec_row%0d_cyc%0d", r, c), outs(),
              int'({vecs[r].rst, vecs[r].busy, vecs[r].ready, vecs[r].done, vecs[r].err}));
      end
    end

    // Mid-sequence reset: stall in RELEASE with acks high, then hit async reset between edges.
    req_v_i      = 1'b1;
    domain_ack_i = 2'b11;
    tick();
    req_v_i = 1'b0;
    check("mid_assert", int'(domain_reset_o), 3);
    cyc = 0;
    while (domain_reset_o != 2'b00 && cyc < 60) begin
      cyc++;
      tick();
    end
    check("mid_cycles_to_release", cyc, 18);
    tick();
    tick();
    check("mid_release_stall", outs(), int'({2'b00, 1'b1, 1'b0, 1'b0, 1'b0}));
    #3 async_reset_i = 1'b1;
    #1;
    check("mid_async_force", outs(), int'({2'b11, 1'b1, 1'b0, 1'b0, 1'b0}));
    tick();
    check("mid_reset_held", outs(), int'({2'b11, 1'b1, 1'b0, 1'b0, 1'b0}));
    tick();
    async_reset_i = 1'b0;
    reset_run("mid");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
